// File: rtl/instr_decode_pkg.sv
// Shared definitions for the MIPS decode stage.
//   - opcode / funct encodings of the supported 31-instruction subset
//   - bit positions of each instruction in the one-hot RESULT vector
//   - RESULT vector width
//   - skid-buffer state encoding
package instr_decode_pkg;

    localparam int RESULT_W = 54;

    // Primary opcodes (INSTR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type function codes (INSTR[5:0])
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    // One-hot bit positions in RESULT
    localparam logic [4:0] IDX_ADD   = 5'd0;
    localparam logic [4:0] IDX_ADDU  = 5'd1;
    localparam logic [4:0] IDX_SUB   = 5'd2;
    localparam logic [4:0] IDX_SUBU  = 5'd3;
    localparam logic [4:0] IDX_AND   = 5'd4;
    localparam logic [4:0] IDX_OR    = 5'd5;
    localparam logic [4:0] IDX_XOR   = 5'd6;
    localparam logic [4:0] IDX_NOR   = 5'd7;
    localparam logic [4:0] IDX_SLT   = 5'd8;
    localparam logic [4:0] IDX_SLTU  = 5'd9;
    localparam logic [4:0] IDX_SLL   = 5'd10;
    localparam logic [4:0] IDX_SRL   = 5'd11;
    localparam logic [4:0] IDX_SRA   = 5'd12;
    localparam logic [4:0] IDX_SLLV  = 5'd13;
    localparam logic [4:0] IDX_SRLV  = 5'd14;
    localparam logic [4:0] IDX_SRAV  = 5'd15;
    localparam logic [4:0] IDX_JR    = 5'd16;
    localparam logic [4:0] IDX_ADDI  = 5'd17;
    localparam logic [4:0] IDX_ADDIU = 5'd18;
    localparam logic [4:0] IDX_ANDI  = 5'd19;
    localparam logic [4:0] IDX_ORI   = 5'd20;
    localparam logic [4:0] IDX_XORI  = 5'd21;
    localparam logic [4:0] IDX_LW    = 5'd22;
    localparam logic [4:0] IDX_SW    = 5'd23;
    localparam logic [4:0] IDX_BEQ   = 5'd24;
    localparam logic [4:0] IDX_BNE   = 5'd25;
    localparam logic [4:0] IDX_SLTI  = 5'd26;
    localparam logic [4:0] IDX_SLTIU = 5'd27;
    localparam logic [4:0] IDX_LUI   = 5'd28;
    localparam logic [4:0] IDX_J     = 5'd29;
    localparam logic [4:0] IDX_JAL   = 5'd30;

    // Skid-buffer occupancy
    localparam logic [1:0] ST_EMPTY = 2'b00;  // nothing held
    localparam logic [1:0] ST_MAIN  = 2'b01;  // main entry valid
    localparam logic [1:0] ST_FULL  = 2'b10;  // main and skid valid

endpackage

// File: rtl/instr_onehot_decode.sv
// Combinational one-hot decoder for the supported MIPS subset.
// Only opcode and funct are examined; register/shamt fields are ignored.
// Ports:
//   INSTR   in   32-bit instruction word
//   RESULT  out  one-hot decode, all zero for an unsupported encoding
//   ILLEGAL out  encoding matched no supported instruction
module instr_onehot_decode
    import instr_decode_pkg::*;
#(
    parameter int RESULT_W = instr_decode_pkg::RESULT_W
) (
    input  logic [31:0]         INSTR,
    output logic [RESULT_W-1:0] RESULT,
    output logic                ILLEGAL
);

    logic [5:0] opcode;
    logic [5:0] funct;
    logic [4:0] idx;
    logic       hit;
    logic       unused_fields;

    assign opcode        = INSTR[31:26];
    assign funct         = INSTR[5:0];
    assign unused_fields = ^INSTR[25:6];

    always_comb begin
        idx = 5'd0;
        hit = 1'b1;
        unique case (opcode)
            OP_RTYPE: begin
                unique case (funct)
                    FN_ADD:  idx = IDX_ADD;
                    FN_ADDU: idx = IDX_ADDU;
                    FN_SUB:  idx = IDX_SUB;
                    FN_SUBU: idx = IDX_SUBU;
                    FN_AND:  idx = IDX_AND;
                    FN_OR:   idx = IDX_OR;
                    FN_XOR:  idx = IDX_XOR;
                    FN_NOR:  idx = IDX_NOR;
                    FN_SLT:  idx = IDX_SLT;
                    FN_SLTU: idx = IDX_SLTU;
                    FN_SLL:  idx = IDX_SLL;
                    FN_SRL:  idx = IDX_SRL;
                    FN_SRA:  idx = IDX_SRA;
                    FN_SLLV: idx = IDX_SLLV;
                    FN_SRLV: idx = IDX_SRLV;
                    FN_SRAV: idx = IDX_SRAV;
                    FN_JR:   idx = IDX_JR;
                    default: hit = 1'b0;
                endcase
            end
            OP_ADDI:  idx = IDX_ADDI;
            OP_ADDIU: idx = IDX_ADDIU;
            OP_ANDI:  idx = IDX_ANDI;
            OP_ORI:   idx = IDX_ORI;
            OP_XORI:  idx = IDX_XORI;
            OP_LW:    idx = IDX_LW;
            OP_SW:    idx = IDX_SW;
            OP_BEQ:   idx = IDX_BEQ;
            OP_BNE:   idx = IDX_BNE;
            OP_SLTI:  idx = IDX_SLTI;
            OP_SLTIU: idx = IDX_SLTIU;
            OP_LUI:   idx = IDX_LUI;
            OP_J:     idx = IDX_J;
            OP_JAL:   idx = IDX_JAL;
            default:  hit = 1'b0;
        endcase
    end

    assign RESULT  = hit ? (RESULT_W'(1) << idx) : '0;
    assign ILLEGAL = ~hit;

endmodule

// File: rtl/instr_decode_stage.sv
// Registered MIPS decode stage with a 2-entry skid buffer.
// Words are decoded as they arrive and the full decoded set (one-hot
// result, illegal flag, raw word for field extraction, PC) is stored in
// the main or skid entry. The main entry drives the outputs.
// Optional feature macro: DECODE_ILLEGAL_CNT_EN enables the saturating
// illegal-delivery counter on ILLEGAL_CNT; otherwise it is tied to 0.
// Ports:
//   CLK, RST_N (sync, active low), FLUSH (drops everything held/incoming)
//   IN_VALID/IN_READY, INSTR, IN_PC           - fetch side handshake
//   OUT_VALID/OUT_READY, RESULT, RS, RT, RD, SHAMT, IMM16, JADDR,
//   OUT_PC, ILLEGAL                           - control-unit side
//   ILLEGAL_CNT                               - illegal deliveries seen
module instr_decode_stage
    import instr_decode_pkg::*;
#(
    parameter int PC_W     = 32,
    parameter int RESULT_W = instr_decode_pkg::RESULT_W
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                FLUSH,
    input  logic                IN_VALID,
    output logic                IN_READY,
    input  logic [31:0]         INSTR,
    input  logic [PC_W-1:0]     IN_PC,
    output logic                OUT_VALID,
    input  logic                OUT_READY,
    output logic [RESULT_W-1:0] RESULT,
    output logic [4:0]          RS,
    output logic [4:0]          RT,
    output logic [4:0]          RD,
    output logic [4:0]          SHAMT,
    output logic [15:0]         IMM16,
    output logic [25:0]         JADDR,
    output logic [PC_W-1:0]     OUT_PC,
    output logic                ILLEGAL,
    output logic [15:0]         ILLEGAL_CNT
);

    logic [1:0]          state, state_nx;
    logic                in_ready_q;
    logic                accept, out_xfer;
    logic                load_main_dec, load_main_skid, load_skid;

    logic [RESULT_W-1:0] dec_result, main_result, skid_result;
    logic                dec_illegal, main_illegal, skid_illegal;
    logic [31:0]         main_instr, skid_instr;
    logic [PC_W-1:0]     main_pc, skid_pc;

    instr_onehot_decode #(.RESULT_W(RESULT_W)) u_dec (
        .INSTR   (INSTR),
        .RESULT  (dec_result),
        .ILLEGAL (dec_illegal)
    );

    assign IN_READY  = in_ready_q;
    assign OUT_VALID = (state != ST_EMPTY);
    assign accept    = IN_VALID & in_ready_q;
    assign out_xfer  = OUT_VALID & OUT_READY;

    always_comb begin
        state_nx = state;
        if (FLUSH) begin
            state_nx = ST_EMPTY;
        end else begin
            unique case (state)
                ST_EMPTY: if (accept) state_nx = ST_MAIN;
                ST_MAIN: begin
                    if (accept && !out_xfer)      state_nx = ST_FULL;
                    else if (!accept && out_xfer) state_nx = ST_EMPTY;
                end
                ST_FULL:  if (out_xfer) state_nx = ST_MAIN;
                default:  state_nx = ST_EMPTY;
            endcase
        end
    end

    // Main reloads from the decoder when it is empty or draining this cycle;
    // otherwise an accepted word parks in skid until main drains.
    assign load_main_dec  = !FLUSH && accept &&
                            ((state == ST_EMPTY) || ((state == ST_MAIN) && out_xfer));
    assign load_skid      = !FLUSH && accept && (state == ST_MAIN) && !out_xfer;
    assign load_main_skid = !FLUSH && (state == ST_FULL) && out_xfer;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state        <= ST_EMPTY;
            in_ready_q   <= 1'b1;
            main_result  <= '0;
            main_illegal <= 1'b0;
            main_instr   <= '0;
            main_pc      <= '0;
            skid_result  <= '0;
            skid_illegal <= 1'b0;
            skid_instr   <= '0;
            skid_pc      <= '0;
        end else begin
            state      <= state_nx;
            in_ready_q <= (state_nx != ST_FULL);
            if (load_main_dec) begin
                main_result  <= dec_result;
                main_illegal <= dec_illegal;
                main_instr   <= INSTR;
                main_pc      <= IN_PC;
            end else if (load_main_skid) begin
                main_result  <= skid_result;
                main_illegal <= skid_illegal;
                main_instr   <= skid_instr;
                main_pc      <= skid_pc;
            end
            if (load_skid) begin
                skid_result  <= dec_result;
                skid_illegal <= dec_illegal;
                skid_instr   <= INSTR;
                skid_pc      <= IN_PC;
            end
        end
    end

    assign RESULT  = main_result;
    assign ILLEGAL = main_illegal;
    assign OUT_PC  = main_pc;
    assign RS      = main_instr[25:21];
    assign RT      = main_instr[20:16];
    assign RD      = main_instr[15:11];
    assign SHAMT   = main_instr[10:6];
    assign IMM16   = main_instr[15:0];
    assign JADDR   = main_instr[25:0];

`ifdef DECODE_ILLEGAL_CNT_EN
    // Counts only completed deliveries; a transfer coinciding with FLUSH
    // still completes and is counted, entries dropped by FLUSH are not.
    logic [15:0] illegal_cnt_q;
    always_ff @(posedge CLK) begin
        if (!RST_N)
            illegal_cnt_q <= '0;
        else if (out_xfer && main_illegal && (illegal_cnt_q != 16'hFFFF))
            illegal_cnt_q <= illegal_cnt_q + 16'd1;
    end
    assign ILLEGAL_CNT = illegal_cnt_q;
`else
    assign ILLEGAL_CNT = '0;
`endif

endmodule

// File: tb/tb_instr_decode_stage.sv
// Directed self-checking bench for instr_decode_stage.
module tb_instr_decode_stage;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        FLUSH = 1'b0;
    logic        IN_VALID = 1'b0;
    logic        IN_READY;
    logic [31:0] INSTR = '0;
    logic [31:0] IN_PC = '0;
    logic        OUT_VALID;
    logic        OUT_READY = 1'b0;
    logic [53:0] RESULT;
    logic [4:0]  RS, RT, RD, SHAMT;
    logic [15:0] IMM16;
    logic [25:0] JADDR;
    logic [31:0] OUT_PC;
    logic        ILLEGAL;
    logic [15:0] ILLEGAL_CNT;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    instr_decode_stage #(.PC_W(32), .RESULT_W(54)) dut (
        .CLK(CLK), .RST_N(RST_N), .FLUSH(FLUSH),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY), .INSTR(INSTR), .IN_PC(IN_PC),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .RESULT(RESULT),
        .RS(RS), .RT(RT), .RD(RD), .SHAMT(SHAMT), .IMM16(IMM16), .JADDR(JADDR),
        .OUT_PC(OUT_PC), .ILLEGAL(ILLEGAL), .ILLEGAL_CNT(ILLEGAL_CNT)
    );

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [5:0] funct_of(int idx);
        case (idx)
            0: return 6'h20;  1: return 6'h21;  2: return 6'h22;  3: return 6'h23;
            4: return 6'h24;  5: return 6'h25;  6: return 6'h26;  7: return 6'h27;
            8: return 6'h2A;  9: return 6'h2B; 10: return 6'h00; 11: return 6'h02;
           12: return 6'h03; 13: return 6'h04; 14: return 6'h06; 15: return 6'h07;
           default: return 6'h08;
        endcase
    endfunction

    function automatic logic [5:0] opcode_of(int idx);
        case (idx)
           17: return 6'h08; 18: return 6'h09; 19: return 6'h0C; 20: return 6'h0D;
           21: return 6'h0E; 22: return 6'h23; 23: return 6'h2B; 24: return 6'h04;
           25: return 6'h05; 26: return 6'h0A; 27: return 6'h0B; 28: return 6'h0F;
           29: return 6'h02; default: return 6'h03;
        endcase
    endfunction

    // Legal word for RESULT index idx, with non-trivial register fields.
    function automatic logic [31:0] legal_word(int idx);
        logic [4:0] a;
        a = 5'(idx);
        if (idx < 17)
            return {6'h00, a, ~a, a + 5'd1, a + 5'd2, funct_of(idx)};
        return {opcode_of(idx), a, a + 5'd3, 16'(idx * 16'h0101)};
    endfunction

    task automatic send(input logic [31:0] w, input logic [31:0] pc);
        IN_VALID = 1'b1;
        INSTR    = w;
        IN_PC    = pc;
        step();
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        step();
        step();
        n_checks++;
        if (OUT_VALID !== 1'b0 || IN_READY !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_hs out_valid=%b in_ready=%b required 0/1", OUT_VALID, IN_READY);
        end
        n_checks++;
        if (RESULT !== 54'd0 || ILLEGAL !== 1'b0 || OUT_PC !== 32'd0 ||
            {RS, RT, RD, SHAMT, IMM16, JADDR} !== 62'd0 || ILLEGAL_CNT !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_data result=%h ill=%b pc=%h cnt=%h required all zero",
                     RESULT, ILLEGAL, OUT_PC, ILLEGAL_CNT);
        end
        RST_N = 1'b1;
        step();
    endtask

    task automatic test_stream();
        logic [31:0] w;
        logic [53:0] exp;
        OUT_READY = 1'b1;
        for (int i = 0; i <= 30; i++) begin
            w   = legal_word(i);
            exp = 54'd1 << i;
            send(w, 32'h1000 + 32'(i * 4));
            n_checks++;
            if (OUT_VALID !== 1'b1 || RESULT !== exp || ILLEGAL !== 1'b0 ||
                OUT_PC !== 32'h1000 + 32'(i * 4) || IN_READY !== 1'b1) begin
                n_fail++;
                $display("FAIL stream idx=%0d valid=%b result=%h required %h ill=%b pc=%h",
                         i, OUT_VALID, RESULT, exp, ILLEGAL, OUT_PC);
            end
            n_checks++;
            if (RS !== w[25:21] || RT !== w[20:16] || RD !== w[15:11] ||
                SHAMT !== w[10:6] || IMM16 !== w[15:0] || JADDR !== w[25:0]) begin
                n_fail++;
                $display("FAIL stream_fields idx=%0d rs=%h rt=%h rd=%h sh=%h imm=%h required word %h",
                         i, RS, RT, RD, SHAMT, IMM16, w);
            end
        end
        IN_VALID = 1'b0;
        step();
        n_checks++;
        if (OUT_VALID !== 1'b0 || IN_READY !== 1'b1) begin
            n_fail++;
            $display("FAIL stream_drain out_valid=%b in_ready=%b required 0/1", OUT_VALID, IN_READY);
        end
    endtask

    task automatic test_special();
        OUT_READY = 1'b1;
        send(32'h0000_0000, 32'h40);
        n_checks++;
        if (RESULT !== (54'd1 << 10) || ILLEGAL !== 1'b0 || OUT_VALID !== 1'b1) begin
            n_fail++;
            $display("FAIL zero_word result=%h ill=%b required bit10 only, ill 0", RESULT, ILLEGAL);
        end
        send(32'hFC00_0000, 32'h44);
        n_checks++;
        if (RESULT !== 54'd0 || ILLEGAL !== 1'b1 || OUT_VALID !== 1'b1 || OUT_PC !== 32'h44) begin
            n_fail++;
            $display("FAIL op3f result=%h ill=%b valid=%b required 0/1/1", RESULT, ILLEGAL, OUT_VALID);
        end
        send(32'h0022_1801, 32'h48);  // R-type funct 0x01 is unsupported
        n_checks++;
        if (RESULT !== 54'd0 || ILLEGAL !== 1'b1) begin
            n_fail++;
            $display("FAIL funct01 result=%h ill=%b required 0/1", RESULT, ILLEGAL);
        end
        send(32'h2001_0020, 32'h4C);  // ADDI whose low bits look like an R-type ADD
        n_checks++;
        if (RESULT !== (54'd1 << 17) || ILLEGAL !== 1'b0) begin
            n_fail++;
            $display("FAIL addi_alias result=%h ill=%b required bit17", RESULT, ILLEGAL);
        end
        IN_VALID = 1'b0;
        step();
    endtask

    task automatic test_backpressure();
        OUT_READY = 1'b0;
        send(32'h2001_0005, 32'h200);
        n_checks++;
        if (OUT_VALID !== 1'b1 || RESULT !== (54'd1 << 17) || RT !== 5'd1 ||
            IMM16 !== 16'h0005 || IN_READY !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_first valid=%b result=%h rt=%0d imm=%h rdy=%b required ADDI",
                     OUT_VALID, RESULT, RT, IMM16, IN_READY);
        end
        send(32'h8C22_0004, 32'h204);
        n_checks++;
        if (IN_READY !== 1'b0 || RESULT !== (54'd1 << 17) || OUT_PC !== 32'h200) begin
            n_fail++;
            $display("FAIL bp_full rdy=%b result=%h pc=%h required 0, ADDI @200", IN_READY, RESULT, OUT_PC);
        end
        IN_VALID = 1'b0;
        step();
        n_checks++;
        if (IN_READY !== 1'b0 || OUT_VALID !== 1'b1 || RESULT !== (54'd1 << 17) ||
            RT !== 5'd1 || IMM16 !== 16'h0005) begin
            n_fail++;
            $display("FAIL bp_hold rdy=%b result=%h rt=%0d imm=%h required held ADDI",
                     IN_READY, RESULT, RT, IMM16);
        end
        OUT_READY = 1'b1;
        step();
        n_checks++;
        if (OUT_VALID !== 1'b1 || RESULT !== (54'd1 << 22) || OUT_PC !== 32'h204 ||
            RS !== 5'd1 || RT !== 5'd2 || IMM16 !== 16'h0004 || IN_READY !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_lw valid=%b result=%h pc=%h rdy=%b required LW @204",
                     OUT_VALID, RESULT, OUT_PC, IN_READY);
        end
        step();
        n_checks++;
        if (OUT_VALID !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_dup out_valid=%b required 0", OUT_VALID);
        end
    endtask

    task automatic test_flush();
        OUT_READY = 1'b0;
        send(32'h0022_1820, 32'h300);
        send(32'h0022_1822, 32'h304);
        n_checks++;
        if (IN_READY !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_pre in_ready=%b required 0", IN_READY);
        end
        FLUSH = 1'b1;
        send(32'h0022_1824, 32'h308);
        FLUSH    = 1'b0;
        IN_VALID = 1'b0;
        n_checks++;
        if (OUT_VALID !== 1'b0 || IN_READY !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_next out_valid=%b in_ready=%b required 0/1", OUT_VALID, IN_READY);
        end
        OUT_READY = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            n_checks++;
            if (OUT_VALID !== 1'b0) begin
                n_fail++;
                $display("FAIL flush_ghost cycle=%0d out_valid=%b pc=%h required 0", k, OUT_VALID, OUT_PC);
            end
        end
        send(32'h3C01_1234, 32'h30C);
        IN_VALID = 1'b0;
        n_checks++;
        if (OUT_VALID !== 1'b1 || RESULT !== (54'd1 << 28) || OUT_PC !== 32'h30C) begin
            n_fail++;
            $display("FAIL flush_after valid=%b result=%h pc=%h required LUI @30C", OUT_VALID, RESULT, OUT_PC);
        end
        step();
    endtask

    task automatic test_reset_midstream();
        OUT_READY = 1'b0;
        send(32'hFC00_0000, 32'h400);
        send(32'h2001_0005, 32'h404);
        RST_N = 1'b0;
        step();
        n_checks++;
        if (OUT_VALID !== 1'b0 || IN_READY !== 1'b1 || RESULT !== 54'd0 || ILLEGAL !== 1'b0 ||
            OUT_PC !== 32'd0 || {RS, RT, RD, SHAMT, IMM16, JADDR} !== 62'd0) begin
            n_fail++;
            $display("FAIL reset_mid valid=%b rdy=%b result=%h ill=%b pc=%h required zeros, rdy 1",
                     OUT_VALID, IN_READY, RESULT, ILLEGAL, OUT_PC);
        end
        RST_N    = 1'b1;
        IN_VALID = 1'b0;
        step();
    endtask

    task automatic test_illegal_cnt();
        logic [15:0] exp3;
`ifdef DECODE_ILLEGAL_CNT_EN
        exp3 = 16'd3;
`else
        exp3 = 16'd0;
`endif
        OUT_READY = 1'b1;
        for (int k = 0; k < 3; k++) send(32'hFC00_0000, 32'h500);
        IN_VALID  = 1'b0;
        step();
        OUT_READY = 1'b0;
        send(32'hFC00_0000, 32'h504);
        IN_VALID = 1'b0;
        FLUSH    = 1'b1;
        step();
        FLUSH = 1'b0;
        step();
        n_checks++;
        if (ILLEGAL_CNT !== exp3) begin
            n_fail++;
            $display("FAIL illegal_cnt got=%0d required %0d", ILLEGAL_CNT, exp3);
        end
`ifdef DECODE_ILLEGAL_CNT_EN
        OUT_READY = 1'b1;
        for (int k = 0; k < 65532; k++) send(32'hFC00_0000, 32'h600);
        IN_VALID = 1'b0;
        step();
        n_checks++;
        if (ILLEGAL_CNT !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL cnt_max got=%h required ffff", ILLEGAL_CNT);
        end
        send(32'hFC00_0000, 32'h604);
        IN_VALID = 1'b0;
        step();
        n_checks++;
        if (ILLEGAL_CNT !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL cnt_sat got=%h required ffff", ILLEGAL_CNT);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_stream();
        test_special();
        test_backpressure();
        test_flush();
        test_reset_midstream();
        test_illegal_cnt();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_decode_stage.md
Name: instr_decode_stage

Overview:
- Registered decode stage producing the 54-bit one-hot instruction vector RESULT that the control unit consumes.
- Accepts 32-bit MIPS instruction words from fetch over a valid/ready handshake.
- Decodes the 31-instruction subset into one-hot form and extracts the register and immediate fields.
- Presents the results downstream through a 2-entry skid buffer, so IN_READY is a registered signal.

Parameters:
- PC_W, 32, width of the PC tag carried alongside each instruction.
- RESULT_W, 54, one-hot vector width; bits 31..RESULT_W-1 are reserved and always 0.

Ports:
- CLK  input  1  single clock, rising edge.
- RST_N  input  1  reset; synchronous, active-low.
- FLUSH  input  1  synchronous flush; discards all held and incoming instructions.
- IN_VALID  input  1  fetch offers INSTR/IN_PC.
- IN_READY  output  1  stage can accept; registered.
- INSTR  input  32  instruction word.
- IN_PC  input  PC_W  PC of INSTR.
- OUT_VALID  output  1  RESULT and fields are valid.
- OUT_READY  input  1  downstream accepts.
- RESULT  output  RESULT_W  one-hot decode.
- RS, RT, RD, SHAMT  output  5 each  INSTR[25:21], [20:16], [15:11], [10:6].
- IMM16  output  16  INSTR[15:0].
- JADDR  output  26  INSTR[25:0].
- OUT_PC  output  PC_W  PC tag.
- ILLEGAL  output  1  the entry matched no supported instruction.
- ILLEGAL_CNT  output  16  illegal count (optional feature).

Behaviour:
- RESULT bit map:
  - 0 ADD, 1 ADDU, 2 SUB, 3 SUBU, 4 AND, 5 OR, 6 XOR, 7 NOR, 8 SLT, 9 SLTU.
  - 10 SLL, 11 SRL, 12 SRA, 13 SLLV, 14 SRLV, 15 SRAV, 16 JR.
  - 17 ADDI, 18 ADDIU, 19 ANDI, 20 ORI, 21 XORI, 22 LW, 23 SW, 24 BEQ, 25 BNE.
  - 26 SLTI, 27 SLTIU, 28 LUI, 29 J, 30 JAL.
- R-type (opcode 0x00) decoded by funct:
  - 0x20..0x27 map to bits 0..7 in order; 0x2A SLT; 0x2B SLTU.
  - 0x00 SLL, 0x02 SRL, 0x03 SRA, 0x04 SLLV, 0x06 SRLV, 0x07 SRAV, 0x08 JR.
- Other opcodes:
  - 0x08 ADDI, 0x09 ADDIU, 0x0C ANDI, 0x0D ORI, 0x0E XORI, 0x23 LW, 0x2B SW.
  - 0x04 BEQ, 0x05 BNE, 0x0A SLTI, 0x0B SLTIU, 0x0F LUI, 0x02 J, 0x03 JAL.
- Decode uses opcode and funct only; rs/rt/rd/shamt contents are never checked. 0x00000000 decodes as SLL (bit 10).
- Any other encoding gives RESULT=0 and ILLEGAL=1; the entry still flows through the handshake.
- Exactly one RESULT bit is set per legal entry.
- Reset (RST_N=0 at a rising edge):
  - OUT_VALID=0, IN_READY=1.
  - RESULT, all fields, OUT_PC and ILLEGAL = 0; ILLEGAL_CNT=0.
  - Both buffer entries invalid. Reset overrides FLUSH and all handshakes.
- Handshakes: input transfer on IN_VALID&IN_READY; output transfer on OUT_VALID&OUT_READY.
- Latency: a word accepted at edge t is on the outputs from edge t (OUT_VALID=1 in cycle t+1) when the main entry is empty or draining.
- Buffer FSM states: EMPTY, MAIN (main entry valid), FULL (main and skid valid).
- EMPTY:
  - accept → MAIN.
- MAIN:
  - accept without output transfer → FULL; the skid entry captures the decoded word.
  - accept with output transfer → MAIN; main entry reloads.
  - output transfer without accept → EMPTY.
  - neither → hold.
- FULL:
  - IN_READY=0.
  - output transfer → MAIN; the skid entry moves to main.
  - else hold.
- IN_READY = (next state != FULL), registered.
- Outputs are stable while OUT_VALID=1 and OUT_READY=0.
- FLUSH=1 at an edge:
  - → EMPTY; any same-cycle input is dropped and any same-cycle output transfer still completes.
  - Next cycle OUT_VALID=0, IN_READY=1.
- Decoding is done before buffering; both entries store the full decoded set.

Optional Feature:
- DECODE_ILLEGAL_CNT_EN defined:
  - ILLEGAL_CNT increments by 1 on each output transfer with ILLEGAL=1.
  - Saturates at 0xFFFF.
  - Cleared only by reset; FLUSH does not clear it.
  - Flushed entries are not counted.
- Undefined: ILLEGAL_CNT is tied to 0 and the counter logic is absent.

Decomposition:
- Package instr_decode_pkg:
  - opcode and funct constants;
  - RESULT bit-index constants (IDX_ADD..IDX_JAL);
  - RESULT_W;
  - buffer state encoding.
- One sub-module, instr_onehot_decode: combinational, takes INSTR and returns RESULT and ILLEGAL. It is instantiated once, on the input side.

Test Plan:
- Reset then stream all 31 legal encodings with OUT_READY=1:
  - each RESULT is one-hot at its listed index, ILLEGAL=0;
  - 1-cycle latency; OUT_PC matches.
- INSTR=0x00000000 → RESULT bit 10 only; INSTR=0xFC000000 (opcode 0x3F) → RESULT=0, ILLEGAL=1, OUT_VALID=1.
- Backpressure, OUT_READY=0 while sending ADDI 0x20010005 then LW 0x8C220004:
  - state goes FULL, IN_READY=0;
  - outputs hold ADDI (bit 17, RT=1, IMM16=0x0005).
  - Release OUT_READY → ADDI delivered, then LW (bit 22); no loss or duplication.
- FLUSH asserted in state FULL with IN_VALID=1:
  - next cycle OUT_VALID=0, IN_READY=1;
  - the flushed words never appear.
- RST_N=0 mid-stream in state FULL → all outputs zero next cycle, IN_READY=1.
- With DECODE_ILLEGAL_CNT_EN:
  - 3 illegal words delivered plus 1 flushed → ILLEGAL_CNT=3.
  - Preload to 0xFFFF via 65535 illegal deliveries, then one more → stays 0xFFFF.
